// File: rtl/padding_row_window.sv
// Zero-pads one R/G/B image row per enabled cycle and keeps the last three
// padded rows as a 3-row sliding window for a 3x3 convolution engine.
module padding_row_window #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 416,
  parameter int PAD   = 1,
  localparam int IN_W  = IMG_W * PIX_W,
  localparam int OUT_W = (IMG_W + 2 * PAD) * PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IN_W-1:0]  R_input,
  input  logic [IN_W-1:0]  G_input,
  input  logic [IN_W-1:0]  B_input,
  output logic [OUT_W-1:0] R_row0,
  output logic [OUT_W-1:0] G_row0,
  output logic [OUT_W-1:0] B_row0,
  output logic [OUT_W-1:0] R_row1,
  output logic [OUT_W-1:0] G_row1,
  output logic [OUT_W-1:0] B_row1,
  output logic [OUT_W-1:0] R_row2,
  output logic [OUT_W-1:0] G_row2,
  output logic [OUT_W-1:0] B_row2
);

  localparam int PAD_W = PAD * PIX_W;

  // Channel index 0/1/2 = R/G/B; all channels share the same shift control.
  logic [IN_W-1:0]  in_ch    [3];
  logic [OUT_W-1:0] row0_reg [3];
  logic [OUT_W-1:0] row1_reg [3];
  logic [OUT_W-1:0] row2_reg [3];

  assign in_ch[0] = R_input;
  assign in_ch[1] = G_input;
  assign in_ch[2] = B_input;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      always_ff @(posedge clk) begin
        if (reset) begin
          row0_reg[gi] <= '0;
          row1_reg[gi] <= '0;
          row2_reg[gi] <= '0;
        end else if (en) begin
          row0_reg[gi] <= row1_reg[gi];
          row1_reg[gi] <= row2_reg[gi];
          row2_reg[gi] <= {{PAD_W{1'b0}}, in_ch[gi], {PAD_W{1'b0}}};
        end
      end
    end
  endgenerate

  assign R_row0 = row0_reg[0];
  assign G_row0 = row0_reg[1];
  assign B_row0 = row0_reg[2];
  assign R_row1 = row1_reg[0];
  assign G_row1 = row1_reg[1];
  assign B_row1 = row1_reg[2];
  assign R_row2 = row2_reg[0];
  assign G_row2 = row2_reg[1];
  assign B_row2 = row2_reg[2];

endmodule

// File: tb/tb_padding_row_window.sv
// Bench for padding_row_window: constant vector table, hand-written corner
// sequences, then random rows checked against a queue-based window model.
module tb_padding_row_window;

  localparam int PIX_W = 8;
  localparam int IMG_W = 416;
  localparam int PAD   = 1;
  localparam int IN_W  = IMG_W * PIX_W;
  localparam int OUT_W = (IMG_W + 2 * PAD) * PIX_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [IN_W-1:0]  R_input, G_input, B_input;
  logic [OUT_W-1:0] R_row0, G_row0, B_row0;
  logic [OUT_W-1:0] R_row1, G_row1, B_row1;
  logic [OUT_W-1:0] R_row2, G_row2, B_row2;

  padding_row_window #(.PIX_W(PIX_W), .IMG_W(IMG_W), .PAD(PAD)) dut (
    .clk(clk), .reset(reset), .en(en),
    .R_input(R_input), .G_input(G_input), .B_input(B_input),
    .R_row0(R_row0), .G_row0(G_row0), .B_row0(B_row0),
    .R_row1(R_row1), .G_row1(G_row1), .B_row1(B_row1),
    .R_row2(R_row2), .G_row2(G_row2), .B_row2(B_row2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Expected values indexed k = channel*3 + row (channel 0/1/2 = R/G/B).
  typedef struct {
    bit              rst;
    bit              en;
    logic [31:0]     in_r;
    logic [31:0]     in_g;
    logic [31:0]     in_b;
    logic [8:0][31:0] e;
  } vec_t;

  vec_t vecs [9];

  // Reference model: the rows accepted since the last reset, newest last.
  logic [IN_W-1:0] hq_r[$];
  logic [IN_W-1:0] hq_g[$];
  logic [IN_W-1:0] hq_b[$];

  function automatic logic [OUT_W-1:0] out_sel(int k);
    case (k)
      0: return R_row0;
      1: return R_row1;
      2: return R_row2;
      3: return G_row0;
      4: return G_row1;
      5: return G_row2;
      6: return B_row0;
      7: return B_row1;
      default: return B_row2;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] pad_row(logic [IN_W-1:0] x);
    logic [OUT_W-1:0] w;
    w = OUT_W'(x);
    return w << (PAD * PIX_W);
  endfunction

  function automatic logic [OUT_W-1:0] model_exp(int ch, int row);
    int idx;
    case (ch)
      0: begin idx = hq_r.size() - 3 + row; if (idx >= 0) return pad_row(hq_r[idx]); end
      1: begin idx = hq_g.size() - 3 + row; if (idx >= 0) return pad_row(hq_g[idx]); end
      default: begin idx = hq_b.size() - 3 + row; if (idx >= 0) return pad_row(hq_b[idx]); end
    endcase
    return '0;
  endfunction

  function automatic logic [IN_W-1:0] rand_row();
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [8:0][31:0] uni(logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
    return {e2, e1, e0, e2, e1, e0, e2, e1, e0};
  endfunction

  task automatic check(string name, logic [OUT_W-1:0] act, logic [OUT_W-1:0] exp);
    int p;
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      p = 0;
      for (int i = 0; i < IMG_W + 2 * PAD; i++) begin
        if (act[i*PIX_W +: PIX_W] !== exp[i*PIX_W +: PIX_W]) begin
          p = i;
          break;
        end
      end
      $display("FAIL %s: first bad pixel %0d actual %h required %h",
               name, p, act[p*PIX_W +: PIX_W], exp[p*PIX_W +: PIX_W]);
    end
  endtask

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // One clock edge with the given controls; keeps the model in step.
  task automatic drive(bit rst, bit e, logic [IN_W-1:0] r, logic [IN_W-1:0] g, logic [IN_W-1:0] b);
    reset = rst; en = e; R_input = r; G_input = g; B_input = b;
    @(posedge clk);
    #1;
    if (rst) begin
      hq_r.delete(); hq_g.delete(); hq_b.delete();
    end else if (e) begin
      hq_r.push_back(r); hq_g.push_back(g); hq_b.push_back(b);
      if (hq_r.size() > 3) begin
        void'(hq_r.pop_front()); void'(hq_g.pop_front()); void'(hq_b.pop_front());
      end
    end
  endtask

  task automatic check_model(string tag);
    for (int ch = 0; ch < 3; ch++)
      for (int row = 0; row < 3; row++)
        check($sformatf("%s_ch%0d_row%0d", tag, ch, row), out_sel(ch * 3 + row), model_exp(ch, row));
  endtask

  initial begin
    logic [IN_W-1:0] x;
    reset = 1'b1; en = 1'b0;
    R_input = '0; G_input = '0; B_input = '0;

    vecs[0] = '{rst: 1, en: 1, in_r: 32'hFFFF, in_g: 32'hFFFF, in_b: 32'hFFFF, e: uni(0, 0, 0)};
    vecs[1] = '{rst: 0, en: 0, in_r: 32'h5, in_g: 32'h5, in_b: 32'h5, e: uni(0, 0, 0)};
    vecs[2] = '{rst: 0, en: 1, in_r: 240, in_g: 240, in_b: 240, e: uni(0, 0, 32'hF000)};
    vecs[3] = '{rst: 0, en: 1, in_r: 7, in_g: 7, in_b: 7, e: uni(0, 32'hF000, 32'h0700)};
    vecs[4] = '{rst: 0, en: 1, in_r: 240, in_g: 240, in_b: 240, e: uni(32'hF000, 32'h0700, 32'hF000)};
    vecs[5] = '{rst: 0, en: 1, in_r: 7, in_g: 7, in_b: 7, e: uni(32'h0700, 32'hF000, 32'h0700)};
    vecs[6] = '{rst: 0, en: 0, in_r: 32'h1234, in_g: 32'h55, in_b: 32'h99, e: uni(32'h0700, 32'hF000, 32'h0700)};
    vecs[7] = '{rst: 1, en: 1, in_r: 32'h77, in_g: 32'h77, in_b: 32'h77, e: uni(0, 0, 0)};
    vecs[8] = '{rst: 0, en: 1, in_r: 1, in_g: 2, in_b: 3,
                e: {32'h300, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0}};

    for (int i = 0; i < 9; i++) begin
      reset = vecs[i].rst; en = vecs[i].en;
      R_input = IN_W'(vecs[i].in_r);
      G_input = IN_W'(vecs[i].in_g);
      B_input = IN_W'(vecs[i].in_b);
      @(posedge clk);
      #1;
      for (int k = 0; k < 9; k++)
        check($sformatf("vec%0d_out%0d", i, k), out_sel(k), OUT_W'(vecs[i].e[k]));
    end

    // Edge padding: first and last pixels land one slot in, pad bytes stay zero.
    drive(1, 0, '0, '0, '0);
    x = '0;
    x[7:0] = 8'hAA;
    x[IN_W-1 -: 8] = 8'h55;
    drive(0, 1, x, x, x);
    check8("edge_first_pixel", R_row2[15:8], 8'hAA);
    check8("edge_last_pixel", R_row2[3335:3328], 8'h55);
    check8("edge_left_pad", R_row2[7:0], 8'h00);
    check8("edge_right_pad", R_row2[3343:3336], 8'h00);
    check_model("edge");

    // Hold: fill with random rows, then toggle inputs with en low.
    for (int i = 0; i < 3; i++) drive(0, 1, rand_row(), rand_row(), rand_row());
    check_model("fill");
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, rand_row(), rand_row(), rand_row());
      check_model($sformatf("hold%0d", i));
    end
    drive(1, 1, rand_row(), rand_row(), rand_row());
    check_model("reset_over_en");
    drive(0, 1, rand_row(), rand_row(), rand_row());
    check_model("restart");

    // Random stream with occasional holds and mid-stream resets.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70,
            rand_row(), rand_row(), rand_row());
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
